// File: rtl/ahb_wait_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_wait_sram_slave_if
//   AHB-Lite signal bundle between one master-side driver and the
//   ahb_wait_sram_slave responder.
//
//   Address/control : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST
//   Write data      : HWDATA (data phase)
//   Bus ready       : HREADY (muxed ready of the active slave)
//   Slave response  : HREADYOUT, HRESP, HRDATA
// ---------------------------------------------------------------------------
interface ahb_wait_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_wait_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_wait_sram_slave
//   AHB-Lite responder backing one decoded region with a 32-bit word SRAM.
//   Every OKAY transfer is stretched by WAIT_STATES cycles of HREADYOUT low;
//   misaligned or illegal-size accesses get the two-cycle ERROR response.
//   Byte, halfword and word writes use byte-lane enables; reads always
//   return the full word.
//
//   Parameters
//     ADDR_W      : word-address bits, depth = 2**ADDR_W words
//     WAIT_STATES : wait cycles before each OKAY completion (0..15)
//
//   Ports
//     HCLK   : bus clock, rising edge
//     HRESET : synchronous, active-high reset
//     bus    : AHB-Lite slave modport (address/control, HWDATA, HREADY in;
//              HREADYOUT, HRESP, HRDATA out)
// ---------------------------------------------------------------------------
module ahb_wait_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_wait_sram_slave_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    // Registered address-phase fields, valid for the current data phase.
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH];

    logic              can_accept;
    logic              accept;
    logic              addr_err;
    logic [3:0]        lane_en;
    logic              commit;

    // Only the cycles in which we drive HREADYOUT high can end a data phase,
    // so only those may accept the next address phase.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                        (state_q == ST_ERR2);
    assign accept     = can_accept & bus.HSEL & bus.HREADY & bus.HTRANS[1];

    assign addr_err = (bus.HSIZE == 2'b11) ||
                      ((bus.HSIZE == SIZE_HALF) && bus.HADDR[0]) ||
                      ((bus.HSIZE == SIZE_WORD) && (bus.HADDR[1:0] != 2'b00));

    // -----------------------------------------------------------------------
    // State, counter and address-phase registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= bus.HADDR[ADDR_W+1:2];
                off_q   <= bus.HADDR[1:0];
                size_q  <= bus.HSIZE;
                write_q <= bus.HWRITE;
                err_q   <= addr_err;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (!accept) begin
                    state_d = ST_IDLE;
                end else if (addr_err) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Byte-lane enables from the registered size and offset
    // -----------------------------------------------------------------------
    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            SIZE_BYTE: lane_en = 4'b0001 << off_q;
            SIZE_HALF: lane_en = off_q[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_en = 4'b1111;
            default:   lane_en = 4'b0000;
        endcase
    end

    // A reset arriving on the commit edge wins: the write is dropped along
    // with the rest of the transfer.
    assign commit = (state_q == ST_DONE) && write_q && !err_q && !HRESET;

    // -----------------------------------------------------------------------
    // SRAM array
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset so it maps onto a plain RAM macro; its
    // contents are undefined until written.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int n = 0; n < 4; n++) begin
                if (lane_en[n]) begin
                    mem[idx_q][8*n +: 8] <= bus.HWDATA[8*n +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response outputs, decoded from the registered state only
    // -----------------------------------------------------------------------
    assign bus.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign bus.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign bus.HRDATA    = ((state_q == ST_DONE) && !write_q) ? mem[idx_q] : 32'h0;

    // Bits with no function here: burst type, aliased upper address bits and
    // the SEQ/NONSEQ distinction.
    logic unused_bits;
    assign unused_bits = ^{bus.HBURST, bus.HADDR[31:ADDR_W+2], bus.HTRANS[0]};

endmodule
